// File: rtl/led_pattern_engine.sv
// Multi-mode LED pattern generator: bounce, rotate, fill/drain bar and blink,
// stepped by a power-of-two tick divider with run-time speed select.
module led_pattern_engine #(
   parameter int N_LEDS   = 10,
   parameter int DOT_W    = 1,
   parameter int BASE_DIV = 18,
   parameter int SPD_BITS = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                dir,
   input  logic [1:0]          mode,
   input  logic [SPD_BITS-1:0] speed,
   output logic [N_LEDS-1:0]   leds,
   output logic                end_pulse
);

   localparam int DIV_W = BASE_DIV + 2**SPD_BITS - 1;
   localparam int POS_W = $clog2(N_LEDS + 1);
   localparam logic [POS_W-1:0] ROT_LAST   = POS_W'(N_LEDS - 1);
   localparam logic [POS_W-1:0] BOUNCE_MAX = POS_W'(N_LEDS - DOT_W);
   localparam logic [POS_W-1:0] FILL_MAX   = POS_W'(N_LEDS);

   typedef enum logic [1:0] {BOUNCE = 2'd0, ROTATE = 2'd1, FILL = 2'd2, BLINK = 2'd3} mode_t;

   logic [DIV_W-1:0]    r_div;
   logic [POS_W-1:0]    r_pos;
   logic                r_up;
   logic                r_side;
   mode_t               r_mode;
   logic [SPD_BITS-1:0] r_speed;
   logic                r_endEv;

   logic [DIV_W-1:0]    w_divLast;
   logic                w_tick;
   logic                w_change;
   logic [POS_W-1:0]    w_posMax;
   logic [POS_W-1:0]    w_posNext;
   logic                w_upNext;
   logic                w_endNext;
   logic [2*N_LEDS-1:0] w_shifted;
   logic [N_LEDS-1:0]   w_lowMask;
   logic [N_LEDS-1:0]   w_highMask;
   logic [N_LEDS-1:0]   w_decode;

   assign w_divLast = (DIV_W'(1) << (BASE_DIV + int'(r_speed))) - DIV_W'(1);
   assign w_tick    = en && (r_div == w_divLast);
   assign w_change  = (mode_t'(mode) != r_mode) || (speed != r_speed);

   // Next position on a tick; bounce and fill share the reverse-at-end rule.
   always_comb begin
      w_posNext = r_pos;
      w_upNext  = r_up;
      w_endNext = 1'b0;
      w_posMax  = (r_mode == FILL) ? FILL_MAX : BOUNCE_MAX;
      case (r_mode)
         BOUNCE, FILL: begin
            if (r_up) begin
               if (r_pos == w_posMax) begin
                  w_upNext  = 1'b0;
                  w_posNext = r_pos - POS_W'(1);
                  w_endNext = 1'b1;
               end else begin
                  w_posNext = r_pos + POS_W'(1);
               end
            end else begin
               if (r_pos == '0) begin
                  w_upNext  = 1'b1;
                  w_posNext = r_pos + POS_W'(1);
                  w_endNext = 1'b1;
               end else begin
                  w_posNext = r_pos - POS_W'(1);
               end
            end
         end
         ROTATE: begin
            if (r_up) begin
               if (r_pos == ROT_LAST) begin
                  w_posNext = '0;
                  w_endNext = 1'b1;
               end else begin
                  w_posNext = r_pos + POS_W'(1);
               end
            end else begin
               if (r_pos == '0) begin
                  w_posNext = ROT_LAST;
                  w_endNext = 1'b1;
               end else begin
                  w_posNext = r_pos - POS_W'(1);
               end
            end
         end
         BLINK: begin
            w_posNext = POS_W'(!r_pos[0]);
            w_endNext = !r_pos[0];
         end
         default: ;
      endcase
   end

   // Rotate folds the upper half of a double-width shift back onto bit0.
   always_comb begin
      w_shifted  = (2*N_LEDS)'((1 << DOT_W) - 1) << r_pos;
      w_lowMask  = (N_LEDS'(1) << r_pos) - N_LEDS'(1);
      w_highMask = ~((N_LEDS'(1) << (N_LEDS - int'(r_pos))) - N_LEDS'(1));
      w_decode   = '0;
      case (r_mode)
         BOUNCE:  w_decode = w_shifted[N_LEDS-1:0];
         ROTATE:  w_decode = w_shifted[N_LEDS-1:0] | w_shifted[2*N_LEDS-1:N_LEDS];
         FILL:    w_decode = r_side ? w_lowMask : w_highMask;
         BLINK:   w_decode = {N_LEDS{r_pos[0]}};
         default: w_decode = '0;
      endcase
   end

   // A mode/speed change restarts the pattern and swallows any coincident tick.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_div     <= '0;
         r_pos     <= '0;
         r_up      <= (mode_t'(mode) == FILL) ? 1'b1 : dir;
         r_side    <= dir;
         r_mode    <= mode_t'(mode);
         r_speed   <= speed;
         r_endEv   <= 1'b0;
         leds      <= '0;
         end_pulse <= 1'b0;
      end else begin
         if (w_change) begin
            r_div   <= '0;
            r_pos   <= '0;
            r_up    <= (mode_t'(mode) == FILL) ? 1'b1 : dir;
            r_side  <= dir;
            r_mode  <= mode_t'(mode);
            r_speed <= speed;
            r_endEv <= 1'b0;
         end else if (w_tick) begin
            r_div   <= '0;
            r_pos   <= w_posNext;
            r_up    <= w_upNext;
            r_endEv <= w_endNext;
         end else if (en) begin
            r_div   <= r_div + DIV_W'(1);
            r_endEv <= 1'b0;
         end
         if (en) begin
            leds      <= w_decode;
            end_pulse <= r_endEv;
         end else begin
            end_pulse <= 1'b0;
         end
      end
   end

endmodule
